regbank_write_decode: RTL and testbench



---
 rtl/regbank_pkg.sv | 9 +
 rtl/regbank_write_decode_decoder5to32_en.sv | 14 +
 rtl/regbank_write_decode.sv | 72 +++++++
 tb/tb_regbank_write_decode.sv | 128 ++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared sizes and slice-offset helper for the register bank
package regbank_pkg;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int XZR_IDX   = 31;
  function automatic int slice_off(input int i, input int n);
    return i * n;
  endfunction
endpackage

// File: rtl/regbank_write_decode_decoder5to32_en.sv
// decoder5to32_en: 5-bit index plus enable to 32-bit one-hot, with one excluded index
// Ports: i_en enable, i_idx index, o_onehot one-hot result (bit EXCL never set)
module decoder5to32_en
  import regbank_pkg::*;
#(
  parameter int EXCL = XZR_IDX
) (
  input  logic                 i_en,
  input  logic [REG_IDX_W-1:0] i_idx,
  output logic [NUM_REGS-1:0]  o_onehot
);
  // The ternary keeps an unknown index from leaking X while disabled
  assign o_onehot = i_en ? ((NUM_REGS'(1) << i_idx) & ~(NUM_REGS'(1) << EXCL)) : '0;
endmodule

// File: rtl/regbank_write_decode.sv
// regbank_write_decode: write side of the 32 x N register bank with forwarding record and write bitmap
// Ports: clk, reset_n (async active-low), clr (sync clear), wr_en/wr_addr/wr_data write request,
//        regs_flat all registers (reg i at [i*N +: N]), written bitmap, fwd_* last-commit record,
//        wr_count saturating commit count
module regbank_write_decode
  import regbank_pkg::*;
#(
  parameter int           N         = 64,
  parameter int           ZERO_IDX  = XZR_IDX,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [REG_IDX_W-1:0]     wr_addr,
  input  logic [N-1:0]             wr_data,
  output logic [NUM_REGS*N-1:0]    regs_flat,
  output logic [NUM_REGS-1:0]      written,
  output logic                     fwd_valid,
  output logic [REG_IDX_W-1:0]     fwd_addr,
  output logic [N-1:0]             fwd_data,
  output logic [15:0]              wr_count
);
  logic [NUM_REGS-1:0]  w_en;
  logic                 w_any;
  logic [NUM_REGS-1:0]  r_written;
  logic                 r_fwd_valid;
  logic [REG_IDX_W-1:0] r_fwd_addr;
  logic [N-1:0]         r_fwd_data;
  logic [15:0]          r_count;
  // clr gates the decoder so a simultaneous write is dropped everywhere at once
  decoder5to32_en #(.EXCL(ZERO_IDX)) u_dec (
    .i_en    (wr_en & ~clr),
    .i_idx   (wr_addr),
    .o_onehot(w_en)
  );
  assign w_any = |w_en;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == ZERO_IDX) begin : g_zero
      assign regs_flat[slice_off(g, N) +: N] = '0;
    end else begin : g_live
      logic [N-1:0] r_q;
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_q <= RESET_VAL;
        else if (clr) r_q <= RESET_VAL;
        else if (w_en[g]) r_q <= wr_data;
      assign regs_flat[slice_off(g, N) +: N] = r_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_written   <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
      r_count     <= '0;
    end else begin
      r_written   <= clr ? '0 : (r_written | w_en);
      r_fwd_valid <= w_any;
      if (w_any) begin
        r_fwd_addr <= wr_addr;
        r_fwd_data <= wr_data;
      end
      r_count <= clr ? '0 : (w_any && r_count != 16'hFFFF) ? r_count + 16'd1 : r_count;
    end
  assign written   = r_written;
  assign fwd_valid = r_fwd_valid;
  assign fwd_addr  = r_fwd_addr;
  assign fwd_data  = r_fwd_data;
  assign wr_count  = r_count;
endmodule

// File: tb/tb_regbank_write_decode.sv
// tb_regbank_write_decode: directed self-checking bench for regbank_write_decode
module tb_regbank_write_decode;
  localparam int N = 64;
  logic            clk = 1'b0;
  logic            reset_n, clr, wr_en;
  logic [4:0]      wr_addr;
  logic [N-1:0]    wr_data;
  logic [32*N-1:0] regs_flat, tmp;
  logic [31:0]     written;
  logic            fwd_valid;
  logic [4:0]      fwd_addr;
  logic [N-1:0]    fwd_data;
  logic [15:0]     wr_count;
  int              passes = 0, total = 0;

  regbank_write_decode #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .regs_flat(regs_flat), .written(written), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] slice(input int i);
    return regs_flat[i*N +: N];
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step(); step();
    chk("rst_flat",  N'(|regs_flat), 0);
    chk("rst_written", N'(written), 0);
    chk("rst_fwd_valid", N'(fwd_valid), 0);
    chk("rst_fwd_addr", N'(fwd_addr), 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_count", N'(wr_count), 0);
    reset_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0005;
    step();
    wr_en = 1'b0;
    chk("w5_slice", slice(5), 64'hDEAD_BEEF_0000_0005);
    chk("w5_written", N'(written), 64'h20);
    chk("w5_fwd_valid", N'(fwd_valid), 1);
    chk("w5_fwd_addr", N'(fwd_addr), 5);
    chk("w5_fwd_data", fwd_data, 64'hDEAD_BEEF_0000_0005);
    chk("w5_count", N'(wr_count), 1);
    tmp = regs_flat; tmp[5*N +: N] = '0;
    chk("w5_others", N'(|tmp), 0);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
    step();
    wr_en = 1'b0;
    chk("xzr_slice", slice(31), 0);
    chk("xzr_written", N'(written), 64'h20);
    chk("xzr_fwd_valid", N'(fwd_valid), 0);
    chk("xzr_fwd_addr_hold", N'(fwd_addr), 5);
    chk("xzr_count", N'(wr_count), 1);
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = N'(i * 'h11);
      step();
    end
    wr_en = 1'b0;
    chk("w1to4_slice3", slice(3), 64'h33);
    chk("w1to4_written", N'(written), 64'h3E);
    chk("w1to4_count", N'(wr_count), 5);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h77;
    step();
    clr = 1'b0; wr_en = 1'b0;
    chk("clr_flat", N'(|regs_flat), 0);
    chk("clr_written", N'(written), 0);
    chk("clr_count", N'(wr_count), 0);
    chk("clr_fwd_valid", N'(fwd_valid), 0);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd1;
    step();
    chk("b2b_slice_1", slice(7), 1);
    chk("b2b_valid_1", N'(fwd_valid), 1);
    wr_data = 64'd2;
    step();
    wr_en = 1'b0;
    chk("b2b_slice_2", slice(7), 2);
    chk("b2b_valid_2", N'(fwd_valid), 1);
    step();
    chk("b2b_valid_idle", N'(fwd_valid), 0);
    chk("b2b_fwd_data_hold", fwd_data, 2);
    chk("b2b_count", N'(wr_count), 2);
    wr_addr = 'x; wr_data = 64'hFF;
    step();
    chk("xaddr_written", N'(written), 64'h80);
    chk("xaddr_count", N'(wr_count), 2);
    chk("xaddr_slice7", slice(7), 2);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hAB;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_flat", N'(|regs_flat), 0);
    chk("arst_written", N'(written), 0);
    chk("arst_count", N'(wr_count), 0);
    chk("arst_fwd_valid", N'(fwd_valid), 0);
    step();
    wr_en = 1'b0; reset_n = 1'b1;
    step();
    chk("arst_post_slice9", slice(9), 0);
    chk("arst_post_count", N'(wr_count), 0);
    chk("arst_post_written", N'(written), 0);
    wr_en = 1'b1; wr_addr = 5'd0;
    for (int i = 0; i <= 65536; i++) begin
      wr_data = N'(i);
      step();
    end
    wr_en = 1'b0;
    chk("sat_count", N'(wr_count), 64'hFFFF);
    chk("sat_slice0", slice(0), 64'd65536);
    chk("sat_written", N'(written), 1);
    step();
    chk("sat_count_hold", N'(wr_count), 64'hFFFF);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
